// File: rtl/imm_gen_pipe_if.sv
// Shared immediate-format enum plus the valid/ready bundle between the
// immediate generator stage and its producer/consumer.
package CorePack;
    typedef enum logic [2:0] {
        IMM0    = 3'd0,
        I_IMM   = 3'd1,
        S_IMM   = 3'd2,
        B_IMM   = 3'd3,
        U_IMM   = 3'd4,
        UJ_IMM  = 3'd5,
        CSR_IMM = 3'd6
    } imm_op_enum;
endpackage

interface imm_gen_pipe_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
);
    import CorePack::*;

    logic             in_valid;
    logic             in_ready;
    imm_op_enum       in_op;
    logic [24:0]      in_inst;
    logic [XLEN-1:0]  in_base;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [XLEN-1:0]  out_sum;
    logic [TAG_W-1:0] out_tag;

    // master: the environment (producer + consumer); slave: the stage itself
    modport master (
        output in_valid, in_op, in_inst, in_base, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_sum, out_tag
    );
    modport slave (
        input  in_valid, in_op, in_inst, in_base, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_sum, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Immediate decode + base/imm adder, registered behind a 2-entry skid buffer
// (main drives the outputs, skid absorbs one entry of back-pressure).
module imm_gen_pipe
    import CorePack::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           flush,
    imm_gen_pipe_if.slave  bus
);
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  sum;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [24:0]     i;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_w;
    entry_t          new_e;
    entry_t          main_q, main_d, skid_q, skid_d;
    logic            m_v_q, m_v_d, s_v_q, s_v_d;
    logic            in_fire, out_fire;

    assign i = bus.in_inst;

    // Every format fits in 32 bits; widen to XLEN afterwards.
    always_comb begin
        imm32 = 32'd0;
        unique case (bus.in_op)
            I_IMM:   imm32 = {{20{i[24]}}, i[24:13]};
            S_IMM:   imm32 = {{20{i[24]}}, i[24:18], i[4:0]};
            B_IMM:   imm32 = {{19{i[24]}}, i[24], i[0], i[23:18], i[4:1], 1'b0};
            U_IMM:   imm32 = {i[24:5], 12'b0};
            UJ_IMM:  imm32 = {{11{i[24]}}, i[24], i[12:5], i[13], i[23:14], 1'b0};
            CSR_IMM: imm32 = {27'd0, i[12:8]};
            default: imm32 = 32'd0;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_wide
            assign imm_w = {{(XLEN-32){imm32[31]}}, imm32};
        end else begin : g_narrow
            assign imm_w = imm32;
        end
    endgenerate

    assign new_e.imm = imm_w;
    assign new_e.sum = bus.in_base + imm_w;
    assign new_e.tag = bus.in_tag;

    assign in_fire  = bus.in_valid & ~s_v_q;
    assign out_fire = m_v_q & bus.out_ready;

    always_comb begin
        m_v_d  = m_v_q;
        s_v_d  = s_v_q;
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            // data registers keep their contents; only the flags die
            m_v_d = 1'b0;
            s_v_d = 1'b0;
        end else if (out_fire) begin
            if (s_v_q) begin
                main_d = skid_q;
                s_v_d  = 1'b0;
            end else if (in_fire) begin
                main_d = new_e;
            end else begin
                m_v_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!m_v_q) begin
                main_d = new_e;
                m_v_d  = 1'b1;
            end else begin
                skid_d = new_e;
                s_v_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_v_q  <= 1'b0;
            s_v_q  <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            m_v_q  <= m_v_d;
            s_v_q  <= s_v_d;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign bus.in_ready  = ~s_v_q;
    assign bus.out_valid = m_v_q;
    assign bus.out_imm   = main_q.imm;
    assign bus.out_sum   = main_q.sum;
    assign bus.out_tag   = main_q.tag;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 64-bit instance carries the stimulus and
// a 32-bit instance mirrors its inputs for the narrow-width checks.
module tb_imm_gen_pipe;
    import CorePack::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

    imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) b64 ();
    imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) b32 ();

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (.clk(clk), .rstn(rstn), .flush(flush), .bus(b64));
    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (.clk(clk), .rstn(rstn), .flush(flush), .bus(b32));

    assign b32.in_valid  = b64.in_valid;
    assign b32.in_op     = b64.in_op;
    assign b32.in_inst   = b64.in_inst;
    assign b32.in_base   = b64.in_base[31:0];
    assign b32.in_tag    = b64.in_tag;
    assign b32.out_ready = b64.out_ready;

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input imm_op_enum op, input logic [24:0] inst,
                         input logic [63:0] base, input logic [7:0] tag);
        b64.in_valid = v;
        b64.in_op    = op;
        b64.in_inst  = inst;
        b64.in_base  = base;
        b64.in_tag   = tag;
    endtask

    task automatic test_reset();
        drive(1'b0, IMM0, 25'd0, 64'd0, 8'd0);
        b64.out_ready = 1'b1;
        #3;
        checks++; if (b64.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", b64.out_valid); end
        checks++; if (b64.out_imm !== 64'd0) begin errors++; $display("FAIL reset out_imm: got %h want 0", b64.out_imm); end
        checks++; if (b64.out_sum !== 64'd0) begin errors++; $display("FAIL reset out_sum: got %h want 0", b64.out_sum); end
        checks++; if (b64.out_tag !== 8'd0) begin errors++; $display("FAIL reset out_tag: got %h want 0", b64.out_tag); end
        checks++; if (b64.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", b64.in_ready); end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_i_imm();
        drive(1'b1, I_IMM, 25'h1FFE001, 64'h1000, 8'hA5);
        step();
        drive(1'b0, IMM0, 25'd0, 64'd0, 8'd0);
        checks++; if (b64.out_valid !== 1'b1) begin errors++; $display("FAIL i_imm valid: got %b want 1", b64.out_valid); end
        checks++; if (b64.out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL i_imm imm: got %h want ffffffffffffffff", b64.out_imm); end
        checks++; if (b64.out_sum !== 64'h0FFF) begin errors++; $display("FAIL i_imm sum: got %h want fff", b64.out_sum); end
        checks++; if (b64.out_tag !== 8'hA5) begin errors++; $display("FAIL i_imm tag: got %h want a5", b64.out_tag); end
        step();
        checks++; if (b64.out_valid !== 1'b0) begin errors++; $display("FAIL i_imm drain: got %b want 0", b64.out_valid); end
    endtask

    task automatic test_u_csr();
        drive(1'b1, U_IMM, 25'h1000001, 64'h1000, 8'h11);
        step();
        drive(1'b1, CSR_IMM, 25'h1001F00, 64'h0, 8'h12);
        checks++; if (b64.out_imm !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL u_imm64 imm: got %h want ffffffff80000000", b64.out_imm); end
        checks++; if (b64.out_sum !== 64'hFFFF_FFFF_8000_1000) begin errors++; $display("FAIL u_imm64 sum: got %h want ffffffff80001000", b64.out_sum); end
        checks++; if (b32.out_imm !== 32'h8000_0000) begin errors++; $display("FAIL u_imm32 imm: got %h want 80000000", b32.out_imm); end
        checks++; if (b32.out_sum !== 32'h8000_1000) begin errors++; $display("FAIL u_imm32 sum: got %h want 80001000", b32.out_sum); end
        step();
        drive(1'b0, IMM0, 25'd0, 64'd0, 8'd0);
        checks++; if (b64.out_imm !== 64'd31) begin errors++; $display("FAIL csr_imm64: got %h want 1f", b64.out_imm); end
        checks++; if (b32.out_imm !== 32'd31) begin errors++; $display("FAIL csr_imm32: got %h want 1f", b32.out_imm); end
        checks++; if (b64.out_tag !== 8'h12) begin errors++; $display("FAIL csr tag: got %h want 12", b64.out_tag); end
        step();
    endtask

    task automatic test_other_formats();
        // beq offset -4, then sw offset -8, jal offset +2048, IMM0 and undefined op
        drive(1'b1, B_IMM, 25'h1FC001D, 64'h2000, 8'h21);
        step();
        drive(1'b1, S_IMM, 25'h1FC0018, 64'h100, 8'h22);
        checks++; if (b64.out_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL b_imm imm: got %h want fffffffffffffffc", b64.out_imm); end
        checks++; if (b64.out_sum !== 64'h1FFC) begin errors++; $display("FAIL b_imm sum: got %h want 1ffc", b64.out_sum); end
        step();
        drive(1'b1, UJ_IMM, 25'h0002000, 64'h4000, 8'h23);
        checks++; if (b64.out_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL s_imm imm: got %h want fffffffffffffff8", b64.out_imm); end
        checks++; if (b64.out_sum !== 64'hF8) begin errors++; $display("FAIL s_imm sum: got %h want f8", b64.out_sum); end
        step();
        drive(1'b1, IMM0, 25'h1FFFFFF, 64'h55, 8'h24);
        checks++; if (b64.out_imm !== 64'h800) begin errors++; $display("FAIL uj_imm imm: got %h want 800", b64.out_imm); end
        checks++; if (b64.out_sum !== 64'h4800) begin errors++; $display("FAIL uj_imm sum: got %h want 4800", b64.out_sum); end
        step();
        drive(1'b1, imm_op_enum'(3'd7), 25'h1FFFFFF, 64'h66, 8'h25);
        checks++; if (b64.out_imm !== 64'd0 || b64.out_sum !== 64'h55) begin errors++; $display("FAIL imm0: got imm %h sum %h want 0 55", b64.out_imm, b64.out_sum); end
        step();
        drive(1'b0, IMM0, 25'd0, 64'd0, 8'd0);
        checks++; if (b64.out_imm !== 64'd0 || b64.out_sum !== 64'h66 || b64.out_tag !== 8'h25) begin errors++; $display("FAIL undef op: got imm %h sum %h tag %h want 0 66 25", b64.out_imm, b64.out_sum, b64.out_tag); end
        step();
    endtask

    task automatic test_back_to_back();
        b64.out_ready = 1'b0;
        drive(1'b1, I_IMM, 25'h0002000, 64'h0, 8'd1);  // imm 1
        step();
        drive(1'b1, I_IMM, 25'h0004000, 64'h0, 8'd2);  // imm 2
        step();
        drive(1'b1, I_IMM, 25'h0006000, 64'h0, 8'd3);  // imm 3
        step();
        checks++; if (b64.out_valid !== 1'b1 || b64.out_tag !== 8'd1) begin errors++; $display("FAIL bp main: got v %b tag %0d want 1 1", b64.out_valid, b64.out_tag); end
        checks++; if (b64.in_ready !== 1'b0) begin errors++; $display("FAIL bp in_ready: got %b want 0", b64.in_ready); end
        step();
        checks++; if (b64.out_tag !== 8'd1 || b64.out_imm !== 64'd1) begin errors++; $display("FAIL bp hold: got tag %0d imm %h want 1 1", b64.out_tag, b64.out_imm); end
        b64.out_ready = 1'b1;
        step();
        checks++; if (b64.out_tag !== 8'd2 || b64.out_imm !== 64'd2) begin errors++; $display("FAIL bp second: got tag %0d imm %h want 2 2", b64.out_tag, b64.out_imm); end
        checks++; if (b64.in_ready !== 1'b1) begin errors++; $display("FAIL bp ready rise: got %b want 1", b64.in_ready); end
        step();
        drive(1'b0, IMM0, 25'd0, 64'd0, 8'd0);
        checks++; if (b64.out_valid !== 1'b1 || b64.out_tag !== 8'd3 || b64.out_imm !== 64'd3) begin errors++; $display("FAIL bp third: got v %b tag %0d imm %h want 1 3 3", b64.out_valid, b64.out_tag, b64.out_imm); end
        step();
        checks++; if (b64.out_valid !== 1'b0) begin errors++; $display("FAIL bp drain: got %b want 0", b64.out_valid); end
    endtask

    task automatic test_flush();
        b64.out_ready = 1'b0;
        drive(1'b1, I_IMM, 25'h0008000, 64'h0, 8'd4);
        step();
        drive(1'b1, I_IMM, 25'h000A000, 64'h0, 8'd5);
        step();
        checks++; if (b64.in_ready !== 1'b0) begin errors++; $display("FAIL flush prefill: got in_ready %b want 0", b64.in_ready); end
        drive(1'b1, I_IMM, 25'h000C000, 64'h0, 8'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, IMM0, 25'd0, 64'd0, 8'd0);
        checks++; if (b64.out_valid !== 1'b0 || b64.in_ready !== 1'b1) begin errors++; $display("FAIL flush flags: got v %b rdy %b want 0 1", b64.out_valid, b64.in_ready); end
        checks++; if (b64.out_tag !== 8'd4) begin errors++; $display("FAIL flush data hold: got tag %0d want 4", b64.out_tag); end
        b64.out_ready = 1'b1;
        step();
        checks++; if (b64.out_valid !== 1'b0) begin errors++; $display("FAIL flush no accept: got %b want 0", b64.out_valid); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, I_IMM, 25'h000E000, 64'h10, 8'd7);
        step();
        drive(1'b0, IMM0, 25'd0, 64'd0, 8'd0);
        b64.out_ready = 1'b0;
        checks++; if (b64.out_valid !== 1'b1 || b64.out_tag !== 8'd7) begin errors++; $display("FAIL areset pre: got v %b tag %0d want 1 7", b64.out_valid, b64.out_tag); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (b64.out_valid !== 1'b0 || b64.out_imm !== 64'd0 || b64.out_sum !== 64'd0 || b64.out_tag !== 8'd0) begin errors++; $display("FAIL areset clear: got v %b imm %h sum %h tag %h want all 0", b64.out_valid, b64.out_imm, b64.out_sum, b64.out_tag); end
        checks++; if (b64.in_ready !== 1'b1) begin errors++; $display("FAIL areset in_ready: got %b want 1", b64.in_ready); end
        step();
        rstn = 1'b1;
        b64.out_ready = 1'b1;
        drive(1'b1, S_IMM, 25'h0000005, 64'h20, 8'd8);
        step();
        drive(1'b0, IMM0, 25'd0, 64'd0, 8'd0);
        checks++; if (b64.out_valid !== 1'b1 || b64.out_tag !== 8'd8 || b64.out_sum !== 64'h25) begin errors++; $display("FAIL areset resume: got v %b tag %0d sum %h want 1 8 25", b64.out_valid, b64.out_tag, b64.out_sum); end
        step();
    endtask

    initial begin
        test_reset();
        test_i_imm();
        test_u_csr();
        test_other_formats();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the decode/execute boundary. It decodes the immediate from instruction bits [31:7] for every `CorePack::imm_op_enum` format and sign-extends it to `XLEN` bits. It also computes `base + imm`, used as the branch, JAL or AUIPC target. The result travels through a valid/ready pipeline stage with a 2-entry skid buffer, so back-pressure never drops or reorders an instruction. The stage supports flush and carries a tag sideband.

## Interface
Parameters:
- `XLEN`, 64: datapath width; legal values are 32 and 64.
- `TAG_W`, 8: width of the opaque sideband carried with each entry (ROB index, PC low bits, etc.).

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rstn`, input, 1: reset, asynchronous and active-low.
- `flush`, input, 1: synchronous; kills every buffered entry.
- `in_valid`, input, 1: input entry present.
- `in_ready`, output, 1: stage can accept an entry.
- `in_op`, input, `imm_op_enum`: immediate format (`IMM0`, `I_IMM`, `S_IMM`, `B_IMM`, `U_IMM`, `UJ_IMM`, `CSR_IMM`).
- `in_inst`, input, 25: instruction bits [31:7].
- `in_base`, input, `XLEN`: base operand for the sum (PC or rs1).
- `in_tag`, input, `TAG_W`: sideband.
- `out_valid`, output, 1: output entry present.
- `out_ready`, input, 1: consumer accepts.
- `out_imm`, output, `XLEN`: decoded immediate.
- `out_sum`, output, `XLEN`: `in_base + imm`, modulo 2^XLEN.
- `out_tag`, output, `TAG_W`: sideband.

## Operation
Immediate decode. Let `i` be `in_inst`, so `i[k]` is instruction bit k+7. Every format except `CSR_IMM` and `IMM0` is sign-extended from `i[24]` up to `XLEN`.
- `I_IMM`: `i[24:13]`.
- `S_IMM`: `{i[24:18], i[4:0]}`.
- `B_IMM`: `{i[24], i[0], i[23:18], i[4:1], 0}`.
- `U_IMM`: `{i[24:5], 12'b0}`. With XLEN=32 there is no extension.
- `UJ_IMM`: `{i[24], i[12:5], i[13], i[23:14], 0}`.
- `CSR_IMM`: zero-extended `i[12:8]` (zimm).
- `IMM0` and any undefined encoding: 0.

Sum. `out_sum = base + imm`, truncated to `XLEN`. No overflow flag.

Buffering uses two entries, each holding imm, sum and tag.
- Main register drives the outputs; flag `m_v` drives `out_valid`.
- Skid register has flag `s_v`.
- `in_ready = !s_v`. This is a registered flag with no combinational path from `out_ready`.

The handshake fires on the edge where `valid && ready` is sampled high.
- Accept with main empty, or main firing and skid empty: the new entry loads into main.
- Accept with main full and not firing: the entry loads into skid.
- Main fires with skid full: skid moves to main and skid empties. `in_ready` is 0 that cycle, so no simultaneous accept.
- Main fires, skid empty, no accept: `m_v` clears.

Other rules:
- Ordering is strictly FIFO.
- Decode and sum are computed at the input, before registering.
- `flush` clears `m_v` and `s_v` next edge and overrides any accept that cycle; the data registers hold their values.
- Async reset clears `m_v`, `s_v`, `out_imm`, `out_sum` and `out_tag` to 0 immediately.
- Reset mid-transfer loses all entries; there is no partial state.

## Timing
- Latency: in-fire at edge N gives `out_valid` at N+1 (after that edge).
- Throughput: 1 entry per cycle while `out_ready` stays high.
- Reset values: `out_valid`=0, `out_imm`=0, `out_sum`=0, `out_tag`=0, `in_ready`=1.
- Once `out_valid` is high, `out_imm`, `out_sum` and `out_tag` stay stable until fire or flush.
- `in_ready` falls the cycle after a skid load. It rises the cycle after skid drains, or after flush.
- Combinational path from `in_*` to the registers covers decode plus one XLEN adder; it must close single-cycle.

## Test plan
- I_IMM, XLEN=64: `in_inst=25'h1FFE001` (addi x1,x0,-1), `in_base=64'h1000`, `out_ready=1`. Expect next cycle `out_imm=64'hFFFF_FFFF_FFFF_FFFF`, `out_sum=64'h0FFF`, tag echoed.
- U_IMM from `0x800000B7` (`in_inst=25'h1000001`): XLEN=64 gives `out_imm=64'hFFFF_FFFF_8000_0000`; XLEN=32 gives `32'h8000_0000`. CSR_IMM with zimm=31 gives `out_imm=31`, no extension.
- B_IMM, `beq` offset -4 (`0xFE000EE3`): expect `out_imm=-4`. With `in_base=64'h2000`, expect `out_sum=64'h1FFC`.
- Back-pressure: send tags 1, 2, 3 back-to-back with `out_ready=0` for 3 cycles. Expect tag 1 in main, tag 2 in skid, `in_ready=0`, tag 3 held off. Release: tags leave 1, 2, 3 on consecutive cycles; nothing lost or duplicated.
- Flush with both entries full and `in_valid=1` in the same cycle: next cycle `out_valid=0` and `in_ready=1`; the input that cycle is not accepted.
- Async reset asserted mid-stream, between edges: outputs go to 0 and `out_valid=0` before the next edge. After release the stage accepts normally.
